// File: rtl/ps2_key_serializer_if.sv
// Signal bundle between the hps_io key event source and the PS/2 keyboard serializer.
// dbg_state carries the serializer FSM encoding: 0=IDLE, 1=SHIFT, 2=GAP.
interface ps2_key_serializer_if #(
   parameter int FIFO_DEPTH = 16
);
   logic [10:0]                 ps2_key;
   logic                        ps2_clk;
   logic                        ps2_dat;
   logic                        busy;
   logic                        overflow;
   logic [$clog2(FIFO_DEPTH):0] fifo_level;
   logic [1:0]                  dbg_state;

   // No valid/ready pair here: every change of ps2_key[10] is one event, accepted
   // unconditionally (or dropped with overflow set); line outputs are free-running levels.
   modport master (
      output ps2_key,
      input  ps2_clk, ps2_dat, busy, overflow, fifo_level, dbg_state
   );

   modport slave (
      input  ps2_key,
      output ps2_clk, ps2_dat, busy, overflow, fifo_level, dbg_state
   );
endinterface

// File: rtl/ps2_key_serializer.sv
// Expands hps_io ps2_key events into scancode bytes, queues them, and drives them
// out as device-side PS/2 frames (start, 8 data LSB first, odd parity, stop).
module ps2_key_serializer #(
   parameter int CLK_DIV    = 2000,
   parameter int FIFO_DEPTH = 16,
   parameter int GAP_CYCLES = 4000
) (
   input  logic                clk_sys,
   input  logic                reset,
   ps2_key_serializer_if.slave bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int DIV_W = $clog2(2 * CLK_DIV);
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(2 * CLK_DIV - 1);
   localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
   localparam logic [LVL_W:0]   DEPTH_EXT = (LVL_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2} state_t;

   state_t           state_q, state_d;
   logic             key_tgl_q;
   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic [10:0]      sh_q, sh_d;
   logic [3:0]       bit_q, bit_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             ovf_q, ovf_d;
   logic             clk_q, clk_d, dat_q, dat_d;

   logic             evt, wr_en, pop;
   logic [1:0]       n_bytes;
   logic [7:0]       exp_b [3];
   logic [LVL_W:0]   lvl_sum;

   // Byte expansion order is E0 prefix, then F0 break code, then the scancode.
   always_comb begin
      evt      = bus.ps2_key[10] != key_tgl_q;
      exp_b[0] = bus.ps2_key[7:0];
      exp_b[1] = 8'h00;
      exp_b[2] = 8'h00;
      n_bytes  = 2'd1;
      case ({bus.ps2_key[8], ~bus.ps2_key[9]})
         2'b01: begin
            exp_b[0] = 8'hF0;
            exp_b[1] = bus.ps2_key[7:0];
            n_bytes  = 2'd2;
         end
         2'b10: begin
            exp_b[0] = 8'hE0;
            exp_b[1] = bus.ps2_key[7:0];
            n_bytes  = 2'd2;
         end
         2'b11: begin
            exp_b[0] = 8'hE0;
            exp_b[1] = 8'hF0;
            exp_b[2] = bus.ps2_key[7:0];
            n_bytes  = 2'd3;
         end
         default: ;
      endcase
      lvl_sum = {1'b0, level_q} + (LVL_W + 1)'(n_bytes);
      wr_en   = evt && (lvl_sum <= DEPTH_EXT);
      pop     = (state_q == IDLE) && (level_q != '0);
   end

   always_ff @(posedge clk_sys) begin
      if (wr_en) begin
         for (int i = 0; i < 3; i++) begin
            if (i < int'(n_bytes)) mem_q[wptr_q + PTR_W'(i)] <= exp_b[i];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      rptr_d  = rptr_q;
      sh_d    = sh_q;
      bit_d   = bit_q;
      div_d   = div_q;
      gap_d   = gap_q;
      ovf_d   = ovf_q | (evt & ~wr_en);
      wptr_d  = wr_en ? wptr_q + PTR_W'(n_bytes) : wptr_q;
      level_d = level_q + (wr_en ? LVL_W'(n_bytes) : '0) - (pop ? LVL_W'(1) : '0);
      unique case (state_q)
         IDLE: begin
            if (pop) begin
               sh_d    = {1'b1, ~^mem_q[rptr_q], mem_q[rptr_q], 1'b0};
               rptr_d  = rptr_q + PTR_W'(1);
               bit_d   = 4'd0;
               div_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (div_q == DIV_LAST) begin
               div_d = '0;
               sh_d  = {1'b1, sh_q[10:1]};
               if (bit_q == 4'd10) begin
                  gap_d   = '0;
                  state_d = GAP;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         GAP: begin
            if (gap_q == GAP_LAST) state_d = IDLE;
            else                   gap_d   = gap_q + GAP_W'(1);
         end
         default: state_d = IDLE;
      endcase
      // Lines are registered from next-state so they never glitch.
      clk_d = !((state_d == SHIFT) && (div_d >= DIV_HALF));
      dat_d = (state_d == SHIFT) ? sh_d[0] : 1'b1;
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q   <= IDLE;
         key_tgl_q <= bus.ps2_key[10];
         wptr_q    <= '0;
         rptr_q    <= '0;
         level_q   <= '0;
         sh_q      <= '1;
         bit_q     <= 4'd0;
         div_q     <= '0;
         gap_q     <= '0;
         ovf_q     <= 1'b0;
         clk_q     <= 1'b1;
         dat_q     <= 1'b1;
      end else begin
         state_q   <= state_d;
         key_tgl_q <= bus.ps2_key[10];
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         level_q   <= level_d;
         sh_q      <= sh_d;
         bit_q     <= bit_d;
         div_q     <= div_d;
         gap_q     <= gap_d;
         ovf_q     <= ovf_d;
         clk_q     <= clk_d;
         dat_q     <= dat_d;
      end
   end

   assign bus.ps2_clk    = clk_q;
   assign bus.ps2_dat    = dat_q;
   assign bus.busy       = (state_q != IDLE) | (level_q != '0);
   assign bus.overflow   = ovf_q;
   assign bus.fifo_level = level_q;
   assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_ps2_key_serializer.sv
// Directed bench for ps2_key_serializer: event table plus hand-written timing,
// overflow, wrap-around, back-to-back and reset-mid-frame sequences.
module tb_ps2_key_serializer;
   localparam int CLK_DIV    = 4;
   localparam int FIFO_DEPTH = 4;
   localparam int GAP_CYCLES = 8;
   localparam int BOUND      = 3000;

   typedef struct {
      bit         ext;
      bit         press;
      logic [7:0] code;
      int         n;
      logic [7:0] b0;
      logic [7:0] b1;
      logic [7:0] b2;
   } vec_t;

   logic clk_sys = 1'b0;
   logic rst     = 1'b1;
   int   errors  = 0;
   int   checks  = 0;
   int   cyc     = 0;

   logic [7:0] exp_q [$];
   logic       par_log [$];

   ps2_key_serializer_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

   ps2_key_serializer #(
      .CLK_DIV   (CLK_DIV),
      .FIFO_DEPTH(FIFO_DEPTH),
      .GAP_CYCLES(GAP_CYCLES)
   ) dut (
      .clk_sys(clk_sys),
      .reset  (rst),
      .bus    (bus)
   );

   // ---------------- clock / reset ----------------
   always #5 clk_sys = ~clk_sys;
   always @(posedge clk_sys) cyc <= cyc + 1;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- line monitor ----------------
   logic        prev_clk  = 1'b1;
   int          mon_bits  = 0;
   int          falls     = 0;
   int          frames    = 0;
   int          low_run   = 0;
   int          high_run  = 0;
   int          idle_run  = 0;
   int          last_gap  = -1;
   int          last_rise = 0;
   int          frame_err = 0;
   bit          idle_act  = 1'b0;
   logic [10:0] fr_bits   = '0;
   int          low_len  [11];
   int          high_len [11];

   task automatic frame_done();
      logic [7:0] d;
      d = fr_bits[8:1];
      frames++;
      par_log.push_back(fr_bits[9]);
      if (fr_bits[0] !== 1'b0 || fr_bits[10] !== 1'b1 || fr_bits[9] !== ~^d) frame_err++;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL sb_byte: got 0x%0h expected no byte", d);
      end else begin
         chk("sb_byte", d, exp_q.pop_front());
      end
   endtask

   always @(negedge clk_sys) begin
      if (rst) begin
         mon_bits = 0;
         prev_clk = 1'b1;
         idle_act = 1'b0;
         low_run  = 0;
         high_run = 0;
      end else begin
         if (prev_clk && !bus.ps2_clk) begin
            if (mon_bits < 11) begin
               fr_bits[mon_bits]  = bus.ps2_dat;
               high_len[mon_bits] = high_run;
            end
            mon_bits++;
            falls++;
            low_run = 1;
         end else if (!bus.ps2_clk) begin
            low_run++;
         end else if (!prev_clk) begin
            if (mon_bits >= 1 && mon_bits <= 11) low_len[mon_bits-1] = low_run;
            high_run  = 1;
            last_rise = cyc;
            if (mon_bits >= 11) begin
               frame_done();
               mon_bits = 0;
               idle_act = 1'b1;
               idle_run = 0;
            end
         end else begin
            high_run++;
         end
         if (idle_act) begin
            if (bus.ps2_clk && bus.ps2_dat) idle_run++;
            else begin
               last_gap = idle_run;
               idle_act = 1'b0;
            end
         end
         prev_clk = bus.ps2_clk;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input bit ext, input bit press, input logic [7:0] code);
      logic t;
      @(posedge clk_sys);
      #1;
      t = bus.ps2_key[10];
      bus.ps2_key = {~t, press, ext, code};
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      repeat (2) @(negedge clk_sys);
      while ((bus.busy || mon_bits != 0) && n < BOUND) begin
         @(negedge clk_sys);
         n++;
      end
      chk(name, n < BOUND, 1);
      repeat (2) @(negedge clk_sys);
   endtask

   task automatic wait_level_le(input int lim, input string name);
      int n = 0;
      @(negedge clk_sys);
      while (int'(bus.fifo_level) > lim && n < BOUND) begin
         @(negedge clk_sys);
         n++;
      end
      chk(name, n < BOUND, 1);
   endtask

   task automatic wait_busy_fall(output int at_cyc);
      int n = 0;
      repeat (2) @(negedge clk_sys);
      while (bus.busy && n < BOUND) begin
         @(negedge clk_sys);
         n++;
      end
      chk("busy_fall_bound", n < BOUND, 1);
      at_cyc = cyc;
   endtask

   // ---------------- test sequence ----------------
   vec_t        vecs [7];
   logic [10:0] exp_frame;
   int          fr0, f0, p0, bf_cyc, n;

   initial begin
      vecs[0] = '{ext: 0, press: 1, code: 8'h1C, n: 1, b0: 8'h1C, b1: 8'h00, b2: 8'h00};
      vecs[1] = '{ext: 0, press: 0, code: 8'h1C, n: 2, b0: 8'hF0, b1: 8'h1C, b2: 8'h00};
      vecs[2] = '{ext: 1, press: 1, code: 8'h75, n: 2, b0: 8'hE0, b1: 8'h75, b2: 8'h00};
      vecs[3] = '{ext: 1, press: 0, code: 8'h75, n: 3, b0: 8'hE0, b1: 8'hF0, b2: 8'h75};
      vecs[4] = '{ext: 0, press: 1, code: 8'h00, n: 1, b0: 8'h00, b1: 8'h00, b2: 8'h00};
      vecs[5] = '{ext: 0, press: 0, code: 8'hFF, n: 2, b0: 8'hF0, b1: 8'hFF, b2: 8'h00};
      vecs[6] = '{ext: 1, press: 0, code: 8'hE0, n: 3, b0: 8'hE0, b1: 8'hF0, b2: 8'hE0};

      // Reset state, and a toggle change during reset must not create an event.
      bus.ps2_key = 11'h000;
      rst = 1'b1;
      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      chk("rst_clk", bus.ps2_clk, 1);
      chk("rst_dat", bus.ps2_dat, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_overflow", bus.overflow, 0);
      chk("rst_level", bus.fifo_level, 0);
      chk("rst_state", bus.dbg_state, 0);
      bus.ps2_key = 11'h400;
      @(posedge clk_sys);
      #1 rst = 1'b0;
      repeat (30) @(negedge clk_sys);
      chk("rst_exit_busy", bus.busy, 0);
      chk("rst_exit_frames", frames, 0);

      // Single press 0x1C: bit sequence, pulse widths, busy release.
      exp_frame = 11'h438;
      f0 = falls;
      fr0 = frames;
      exp_q.push_back(8'h1C);
      send(0, 1, 8'h1C);
      wait_busy_fall(bf_cyc);
      repeat (4) @(negedge clk_sys);
      chk("t_frames", frames - fr0, 1);
      chk("t_falls", falls - f0, 11);
      chk("t_busy_fall", bf_cyc - last_rise, 8);
      for (int i = 0; i < 11; i++) begin
         chk($sformatf("t_bit%0d", i), fr_bits[i], exp_frame[i]);
         chk($sformatf("t_low%0d", i), low_len[i], CLK_DIV);
         if (i > 0) chk($sformatf("t_high%0d", i), high_len[i], CLK_DIV);
      end

      // Wrap: 1 + 3 + 3 bytes, the first 3-byte write straddles the array end.
      fr0 = frames;
      exp_q.push_back(8'h11);
      send(0, 1, 8'h11);
      repeat (3) @(posedge clk_sys);
      exp_q.push_back(8'hE0); exp_q.push_back(8'hF0); exp_q.push_back(8'h6B);
      send(1, 0, 8'h6B);
      repeat (3) @(posedge clk_sys);
      wait_level_le(1, "wrap_drain");
      exp_q.push_back(8'hE0); exp_q.push_back(8'hF0); exp_q.push_back(8'h74);
      send(1, 0, 8'h74);
      wait_idle("wrap_idle");
      chk("wrap_frames", frames - fr0, 7);
      chk("wrap_sb_empty", exp_q.size(), 0);
      chk("wrap_overflow", bus.overflow, 0);

      // Extended release 0x75: level 3 then 2, parity 0,1,0.
      p0 = par_log.size();
      exp_q.push_back(8'hE0); exp_q.push_back(8'hF0); exp_q.push_back(8'h75);
      send(1, 0, 8'h75);
      @(posedge clk_sys);
      @(negedge clk_sys);
      chk("ext_level3", bus.fifo_level, 3);
      @(negedge clk_sys);
      chk("ext_level2", bus.fifo_level, 2);
      wait_idle("ext_idle");
      chk("ext_par0", par_log[p0], 0);
      chk("ext_par1", par_log[p0+1], 1);
      chk("ext_par2", par_log[p0+2], 0);
      chk("ext_sb_empty", exp_q.size(), 0);

      // Overflow: second 3-byte event arrives while level=2 and is dropped whole.
      fr0 = frames;
      exp_q.push_back(8'hE0); exp_q.push_back(8'hF0); exp_q.push_back(8'h75);
      send(1, 0, 8'h75);
      @(posedge clk_sys);
      send(1, 0, 8'h6B);
      @(negedge clk_sys);
      chk("ovf_level_before", bus.fifo_level, 2);
      @(negedge clk_sys);
      chk("ovf_set", bus.overflow, 1);
      chk("ovf_level_after", bus.fifo_level, 2);
      wait_idle("ovf_idle");
      chk("ovf_sticky", bus.overflow, 1);
      exp_q.push_back(8'h29);
      send(0, 1, 8'h29);
      wait_idle("ovf_after_idle");
      chk("ovf_frames", frames - fr0, 4);
      chk("ovf_sb_empty", exp_q.size(), 0);

      // Event table.
      for (int i = 0; i < 7; i++) begin
         fr0 = frames;
         exp_q.push_back(vecs[i].b0);
         if (vecs[i].n > 1) exp_q.push_back(vecs[i].b1);
         if (vecs[i].n > 2) exp_q.push_back(vecs[i].b2);
         send(vecs[i].ext, vecs[i].press, vecs[i].code);
         wait_idle($sformatf("vec%0d_idle", i));
         chk($sformatf("vec%0d_frames", i), frames - fr0, vecs[i].n);
         chk($sformatf("vec%0d_sb_empty", i), exp_q.size(), 0);
      end

      // Back-to-back frames from one event: idle-high gap between them.
      last_gap = -1;
      exp_q.push_back(8'hF0); exp_q.push_back(8'h4D);
      send(0, 0, 8'h4D);
      wait_idle("b2b_idle");
      chk("b2b_gap", last_gap, GAP_CYCLES + 1);
      chk("b2b_sb_empty", exp_q.size(), 0);

      // Reset during data bit 4 of E0 while 5A is still queued.
      fr0 = frames;
      send(1, 1, 8'h5A);
      n = 0;
      @(negedge clk_sys);
      while (!(mon_bits == 5 && bus.ps2_clk) && n < BOUND) begin
         @(negedge clk_sys);
         n++;
      end
      chk("mid_reach_bit4", n < BOUND, 1);
      chk("mid_level_queued", bus.fifo_level, 1);
      chk("mid_state_shift", bus.dbg_state, 1);
      f0 = falls;
      @(posedge clk_sys);
      #1 rst = 1'b1;
      @(posedge clk_sys);
      @(negedge clk_sys);
      chk("mid_clk", bus.ps2_clk, 1);
      chk("mid_dat", bus.ps2_dat, 1);
      chk("mid_level", bus.fifo_level, 0);
      chk("mid_busy", bus.busy, 0);
      chk("mid_overflow", bus.overflow, 0);
      chk("mid_state", bus.dbg_state, 0);
      repeat (2) @(posedge clk_sys);
      #1 rst = 1'b0;
      repeat (300) @(negedge clk_sys);
      chk("mid_no_falls", falls - f0, 0);
      chk("mid_no_frames", frames - fr0, 0);
      chk("mid_exit_busy", bus.busy, 0);
      chk("mid_sb_empty", exp_q.size(), 0);

      chk("frame_format_errors", frame_err, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ps2_key_serializer.md
Name: ps2_key_serializer

Overview:
- Converts hps_io `ps2_key` event words into a genuine PS/2 device-side serial stream (clock + data lines) for legacy keyboard controllers in ported cores.
- Buffers expanded scancode bytes in a parametrised FIFO and paces them at a configurable PS/2 bit rate.
- Sits in the emu top level between hps_io and the core's PS2_KBCLK/PS2_KBDAT inputs.

Parameters:
- CLK_DIV, 2000: clk_sys cycles per PS/2 clock half-period; must be >= 2.
- FIFO_DEPTH, 16: byte FIFO depth; power of two, >= 4.
- GAP_CYCLES, 4000: idle cycles (both lines high) after each byte's stop bit; >= 1.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ps2_key  in  11  hps_io event: [10] toggles per event, [9] 1=press/0=release, [8] extended, [7:0] scancode.
- ps2_clk  out  1  PS/2 clock line, idle high.
- ps2_dat  out  1  PS/2 data line, idle high.
- busy  out  1  high while a byte is shifting or the FIFO is non-empty.
- overflow  out  1  sticky; set when an event is dropped.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  bytes queued, excluding the byte in flight.

Behaviour:
- Reset values:
  - ps2_clk=1, ps2_dat=1, busy=0, overflow=0, fifo_level=0.
  - FIFO pointers cleared; FSM in IDLE.
  - Toggle register loaded with ps2_key[10] during reset, so no event is generated on reset exit.
- Event detect:
  - Event when ps2_key[10] differs from the registered copy; the copy updates every cycle.
  - Detect-to-enqueue latency is 1 cycle.
- Expansion, in this order:
  - [8]=1 -> 8'hE0.
  - [9]=0 -> 8'hF0.
  - Then [7:0].
  - n = 1..3 bytes, all written in the same cycle; write pointer advances by n.
- Overflow:
  - If free entries < n, the whole event is dropped (no partial write) and overflow is set.
  - overflow clears only on reset.
- Pop:
  - In IDLE, if the FIFO is non-empty, pop the head into the shift register and go to SHIFT next cycle.
  - Simultaneous write and pop in one cycle is legal: fifo_level' = level + n − 1.
- Frame: 11 bits.
  - Start 0, data LSB first (8 bits), odd parity (data ones + parity = odd), stop 1.
- SHIFT state, per bit:
  - ps2_dat changes to the bit value at bit entry while ps2_clk is high.
  - ps2_clk stays high for CLK_DIV cycles, then low for CLK_DIV cycles.
  - Bit counter 0..10; after bit 10's low phase, ps2_clk returns high and FSM goes to GAP.
- GAP state:
  - Both lines high for GAP_CYCLES cycles, then IDLE.
  - Byte period is 22·CLK_DIV + GAP_CYCLES cycles, plus 1 IDLE cycle.
- FSM states: IDLE -> SHIFT -> GAP -> IDLE. No other transitions except reset.
- busy = (state != IDLE) | (fifo_level != 0).
- Host inhibit (clock held low by the host) is not supported; the lines are output-only.
- Reset mid-frame:
  - Next edge forces both lines high, discards the in-flight byte and FIFO contents, returns to IDLE.
  - No truncated frame may continue after reset.
- Wrap-around:
  - Pointers are modulo FIFO_DEPTH; full/empty are decided from the level counter.
  - A 3-byte write straddling the end of the array wraps correctly.

Test Plan:
- Timing and frame: CLK_DIV=4, GAP_CYCLES=8. Press 0x1C (toggle [10], [9]=1, [8]=0) -> one frame.
  - ps2_dat sequence 0,0,0,1,1,1,0,0,0,0,1 (start, 1C LSB-first, parity 0, stop).
  - 11 ps2_clk low pulses of 4 cycles each; busy falls 8 cycles after the last high phase begins.
- Extended release 0x75 ([9]=0, [8]=1) -> bytes E0, F0, 75 in order.
  - Parity bits 0, 1, 0.
  - fifo_level 3 then 2 the following cycle.
- Overflow: FIFO_DEPTH=4. Extended release, then a second extended release 2 cycles later while level=2.
  - Second event dropped entirely; overflow=1.
  - Only E0,F0,75 emitted; subsequent single-byte events are still accepted.
- Wrap: FIFO_DEPTH=4. Queue 1+3+3 bytes interleaved with drains so writes straddle index 3→0.
  - Output byte order is exactly the input order; no loss.
- Reset mid-frame: assert reset during data bit 4.
  - Next cycle ps2_clk=1, ps2_dat=1, fifo_level=0, busy=0.
  - Reset exit with unchanged ps2_key[10] produces no frame.
- Back-to-back events with the FIFO non-empty:
  - Consecutive frames separated by exactly GAP_CYCLES+1 idle-high cycles.
